// File: rtl/isp_pkg.sv
// ---------------------------------------------------------------------------
// isp_pkg
// Shared definitions for the Bayer front end.
//   bayer_t : colour filter pattern of the sensor, handed to the demosaic
//             datapath (00 BGGR, 01 GBRG, 10 GRBG, 11 RGGB)
//   state_t : frame sequencer states
// ---------------------------------------------------------------------------
package isp_pkg;

    typedef enum logic [1:0] {
        BAYER_BGGR = 2'b00,
        BAYER_GBRG = 2'b01,
        BAYER_GRBG = 2'b10,
        BAYER_RGGB = 2'b11
    } bayer_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_SOF = 2'b01,
        ACTIVE   = 2'b10,
        FLUSH    = 2'b11
    } state_t;

    // The sequencer counts as busy while a frame is in flight.
    function automatic logic state_busy(state_t s);
        return (s == ACTIVE) || (s == FLUSH);
    endfunction

endpackage

// File: rtl/bayer_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// bayer_frame_ctrl_if
// Video stream handshake bundle (AXI4-Stream style sideband subset).
//   tvalid : beat valid              (master -> slave)
//   tuser  : start of frame          (master -> slave)
//   tlast  : end of line             (master -> slave)
//   tready : beat accept             (slave -> master)
// The frame controller uses the slave modport on its input side and the
// master modport on its output side.
// ---------------------------------------------------------------------------
interface bayer_frame_ctrl_if;

    logic tvalid;
    logic tuser;
    logic tlast;
    logic tready;

    modport master (
        output tvalid,
        output tuser,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tuser,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/frame_pos_cnt.sv
// ---------------------------------------------------------------------------
// frame_pos_cnt
// Pixel/line position counter pair for the frame sequencer.
//   clk, rst_n    : clock, asynchronous active-low reset
//   restart       : the beat being counted this cycle is pixel 0, line 0
//   step          : count one beat this cycle
//   tlast         : input end-of-line marker for the current beat
//   beat_pixel    : pixel position of the current beat
//   beat_line     : line position of the current beat
//   line_cnt      : raw registered line counter (ignores restart)
//   at_last_pixel : current beat sits on pixel IMG_WIDTH-1
//   line_end      : current beat closes its line (tlast or last pixel)
// ---------------------------------------------------------------------------
module frame_pos_cnt #(
    parameter int IMG_WIDTH = 640,
    parameter int CNT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic                 step,
    input  logic                 tlast,
    output logic [CNT_WIDTH-1:0] beat_pixel,
    output logic [CNT_WIDTH-1:0] beat_line,
    output logic [CNT_WIDTH-1:0] line_cnt,
    output logic                 at_last_pixel,
    output logic                 line_end
);

    localparam logic [CNT_WIDTH-1:0] LAST_PIXEL = CNT_WIDTH'(IMG_WIDTH - 1);

    logic [CNT_WIDTH-1:0] pixel_q;
    logic [CNT_WIDTH-1:0] line_q;

    // A restarting beat is positioned at the frame origin in the same cycle,
    // so the caller sees its true coordinates without waiting for a clear.
    assign beat_pixel    = restart ? '0 : pixel_q;
    assign beat_line     = restart ? '0 : line_q;
    assign line_cnt      = line_q;
    assign at_last_pixel = (beat_pixel == LAST_PIXEL);

    // A line closes either on the input marker or on reaching the last
    // pixel, so a missing or misplaced tlast can never stall the line count.
    assign line_end = tlast | at_last_pixel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_q <= '0;
            line_q  <= '0;
        end else if (step) begin
            if (line_end) begin
                pixel_q <= '0;
                line_q  <= beat_line + CNT_WIDTH'(1);
            end else begin
                pixel_q <= beat_pixel + CNT_WIDTH'(1);
                line_q  <= beat_line;
            end
        end
    end

endmodule

// File: rtl/bayer_frame_ctrl.sv
// ---------------------------------------------------------------------------
// bayer_frame_ctrl
// Frame sequencer between the 3-line window buffer and the demosaic datapath.
// Holds back the first input line while the window primes, appends one
// flush line after the last input line, shadows the Bayer pattern at frame
// boundaries and flags geometry errors.
//   pixel_clk      : sole clock
//   rst_n          : asynchronous active-low reset
//   cfg_enable     : run request, honoured at frame boundaries
//   cfg_bayer_type : requested pattern, latched on the start-of-frame beat
//   err_clr        : pulse clearing the sticky error flags
//   s_axis         : input stream (tvalid/tuser/tlast in, tready out)
//   m_axis         : window beat stream to the datapath (no backpressure)
//   m_flush        : current output beat is a flush beat
//   bayer_type     : shadowed pattern for the datapath
//   line_idx       : output line index of the current beat
//   pixel_idx      : pixel index of the current beat
//   busy           : a frame is in flight (ACTIVE or FLUSH)
//   err_line       : sticky, line length error
//   err_frame      : sticky, start of frame arrived too early
//   frame_cnt      : completed output frames, wrapping
// ---------------------------------------------------------------------------
module bayer_frame_ctrl
    import isp_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                  pixel_clk,
    input  logic                  rst_n,
    input  logic                  cfg_enable,
    input  logic [1:0]            cfg_bayer_type,
    input  logic                  err_clr,
    bayer_frame_ctrl_if.slave     s_axis,
    bayer_frame_ctrl_if.master    m_axis,
    output logic                  m_flush,
    output logic [1:0]            bayer_type,
    output logic [CNT_WIDTH-1:0]  line_idx,
    output logic [CNT_WIDTH-1:0]  pixel_idx,
    output logic                  busy,
    output logic                  err_line,
    output logic                  err_frame,
    output logic [15:0]           frame_cnt
);

    localparam logic [CNT_WIDTH-1:0] LAST_LINE = CNT_WIDTH'(IMG_HEIGHT - 1);

    state_t               state;
    bayer_t               bayer_q;

    logic                 accept;
    logic                 early_sof;
    logic                 sof_start;
    logic                 frame_beat;
    logic                 err_line_set;
    logic                 last_in_beat;
    logic                 cnt_step;
    logic                 cnt_tlast;

    logic [CNT_WIDTH-1:0] beat_pixel;
    logic [CNT_WIDTH-1:0] beat_line;
    logic [CNT_WIDTH-1:0] line_cnt;
    logic                 at_last_pixel;
    logic                 line_end;

    // Input is stalled only while the flush line is generated.
    assign s_axis.tready = (state != FLUSH);
    assign busy          = state_busy(state);
    assign bayer_type    = bayer_q;

    assign accept = s_axis.tvalid & s_axis.tready;

    // Early start of frame: the raw line counter is used here because the
    // restart decision itself feeds the counter's beat position.
    assign early_sof = (state == ACTIVE) & accept & s_axis.tuser & (line_cnt < LAST_LINE);

    // A new frame starts on tuser while waiting for one, or when an early
    // tuser abandons the frame in progress.
    assign sof_start = accept & s_axis.tuser & cfg_enable &
                       ((state == WAIT_SOF) | early_sof);

    // Beats that belong to a frame: the starting beat plus regular beats.
    assign frame_beat = sof_start | ((state == ACTIVE) & accept & ~early_sof);

    // tlast must coincide exactly with the last pixel of a line.
    assign err_line_set = frame_beat & (s_axis.tlast != at_last_pixel);

    assign last_in_beat = frame_beat & line_end & (beat_line == LAST_LINE);

    // The flush line reuses the pixel counter, which also ends that line.
    assign cnt_step  = frame_beat | (state == FLUSH);
    assign cnt_tlast = s_axis.tlast & (state != FLUSH);

    frame_pos_cnt #(
        .IMG_WIDTH (IMG_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_pos_cnt (
        .clk           (pixel_clk),
        .rst_n         (rst_n),
        .restart       (sof_start),
        .step          (cnt_step),
        .tlast         (cnt_tlast),
        .beat_pixel    (beat_pixel),
        .beat_line     (beat_line),
        .line_cnt      (line_cnt),
        .at_last_pixel (at_last_pixel),
        .line_end      (line_end)
    );

    // Sequencer, error flags and registered output beat. Output beats lag
    // the accepted input beat (or flush cycle) by exactly one clock; input
    // line 0 only primes the window and produces nothing.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bayer_q       <= BAYER_BGGR;
            m_axis.tvalid <= 1'b0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_flush       <= 1'b0;
            line_idx      <= '0;
            pixel_idx     <= '0;
            err_line      <= 1'b0;
            err_frame     <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            m_axis.tvalid <= 1'b0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
            m_flush       <= 1'b0;

            // A new error wins over a simultaneous clear.
            if (err_line_set) begin
                err_line <= 1'b1;
            end else if (err_clr) begin
                err_line <= 1'b0;
            end

            if (early_sof) begin
                err_frame <= 1'b1;
            end else if (err_clr) begin
                err_frame <= 1'b0;
            end

            if (frame_beat && (beat_line != '0)) begin
                m_axis.tvalid <= 1'b1;
                m_axis.tuser  <= (beat_line == CNT_WIDTH'(1)) && (beat_pixel == '0);
                m_axis.tlast  <= at_last_pixel;
                line_idx      <= beat_line - CNT_WIDTH'(1);
                pixel_idx     <= beat_pixel;
            end

            case (state)
                IDLE: begin
                    if (cfg_enable) begin
                        state <= WAIT_SOF;
                    end
                end

                WAIT_SOF: begin
                    if (sof_start) begin
                        bayer_q <= bayer_t'(cfg_bayer_type);
                        state   <= ACTIVE;
                    end else if (!cfg_enable) begin
                        state <= IDLE;
                    end
                end

                ACTIVE: begin
                    // cfg_enable is deliberately not checked here so a frame
                    // in flight always completes.
                    if (sof_start) begin
                        bayer_q <= bayer_t'(cfg_bayer_type);
                    end else if (early_sof) begin
                        state <= IDLE;
                    end else if (last_in_beat) begin
                        state <= FLUSH;
                    end
                end

                FLUSH: begin
                    m_axis.tvalid <= 1'b1;
                    m_flush       <= 1'b1;
                    m_axis.tlast  <= at_last_pixel;
                    line_idx      <= LAST_LINE;
                    pixel_idx     <= beat_pixel;
                    if (at_last_pixel) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= cfg_enable ? WAIT_SOF : IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bayer_frame_ctrl.md
Name: bayer_frame_ctrl

Overview:
- Frame sequencer sitting between the 3-line window buffer and the Bayer demosaic datapath.
- Tracks pixel/line position and holds back the first input line while the window primes.
- Inserts one flush line after the last input line, so the datapath emits exactly IMG_HEIGHT lines per frame.
- Applies Bayer-pattern configuration only at frame boundaries and reports geometry errors.

Parameters:
- IMG_WIDTH, 640, active pixels per line (>=4)
- IMG_HEIGHT, 480, active lines per frame (>=3)
- CNT_WIDTH, 12, width of pixel/line counters (2^CNT_WIDTH > max(IMG_WIDTH, IMG_HEIGHT))

Ports:
- pixel_clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- cfg_enable  in  1  run request; sampled at frame boundaries only
- cfg_bayer_type  in  2  requested pattern (00 BGGR, 01 GBRG, 10 GRBG, 11 RGGB)
- err_clr  in  1  single-cycle pulse; clears sticky error flags
- s_axis_tvalid  in  1  input beat valid
- s_axis_tuser  in  1  start of frame
- s_axis_tlast  in  1  end of line
- s_axis_tready  out  1  input accept
- m_axis_tvalid  out  1  window beat valid to datapath
- m_axis_tuser  out  1  first beat of output frame
- m_axis_tlast  out  1  last beat of output line
- m_flush  out  1  current beat is a flush beat; datapath mirrors the bottom row
- bayer_type  out  2  shadowed pattern to datapath
- line_idx  out  CNT_WIDTH  output line index of current beat
- pixel_idx  out  CNT_WIDTH  pixel index of current beat
- busy  out  1  state is ACTIVE or FLUSH
- err_line  out  1  sticky: tlast at wrong position, or missing tlast
- err_frame  out  1  sticky: tuser arrived before IMG_HEIGHT lines
- frame_cnt  out  16  completed output frames (wraps)

Behaviour:
- Reset:
  - All outputs 0, except s_axis_tready=1 and bayer_type=00.
  - State IDLE; counters 0.
- Handshake:
  - An input beat is accepted when s_axis_tvalid & s_axis_tready.
  - s_axis_tready=0 only in FLUSH.
  - No output backpressure.
- Latency: all m_* outputs are registered, one cycle after the accepted input beat (or after the flush cycle).
- IDLE:
  - Accepted beats are discarded.
  - Go to WAIT_SOF when cfg_enable=1.
- WAIT_SOF:
  - Beats without tuser are discarded.
  - A beat with tuser and cfg_enable=1 latches cfg_bayer_type into bayer_type, zeroes the counters, and enters ACTIVE with that beat counted as pixel 0, line 0.
  - If cfg_enable=0, go to IDLE.
- ACTIVE, per accepted beat:
  - pixel counter increments; line counter increments on tlast.
  - Input line 0 (priming): m_axis_tvalid stays 0.
  - Input lines 1..IMG_HEIGHT-1: m_axis_tvalid=1 with line_idx = input line - 1.
  - m_axis_tuser=1 only on output line 0, pixel 0.
  - m_axis_tlast=1 when pixel_idx = IMG_WIDTH-1.
- Geometry errors:
  - tlast with pixel counter != IMG_WIDTH-1 sets err_line.
  - Pixel IMG_WIDTH-1 without tlast also sets err_line.
  - In both cases the line counter is forced to advance and the pixel counter resets.
  - m_axis_tlast is always generated from the counter, never from the input.
- Leaving ACTIVE:
  - tlast on input line IMG_HEIGHT-1 enters FLUSH.
  - tuser while line counter < IMG_HEIGHT-1 (early frame) sets err_frame and restarts as in WAIT_SOF. The abandoned frame is not counted and has no flush.
- FLUSH:
  - Emits IMG_WIDTH beats, one per cycle, with m_axis_tvalid=1, m_flush=1, line_idx=IMG_HEIGHT-1.
  - Last beat: m_axis_tlast=1 and frame_cnt increments.
  - Next state: ACTIVE-ready WAIT_SOF if cfg_enable=1, else IDLE.
  - Input is stalled throughout FLUSH.
- err_clr: clears both sticky flags. If it coincides with a new error, the set wins.
- cfg_enable drop mid-frame: the current frame completes, including flush; the block returns to IDLE afterwards.
- cfg_bayer_type changes mid-frame: ignored until the next accepted tuser.
- Counter wrap: frame_cnt wraps 0xFFFF -> 0.

Decomposition:
- Shared package isp_pkg:
  - Bayer pattern constants BGGR/GBRG/GRBG/RGGB.
  - State encoding IDLE/WAIT_SOF/ACTIVE/FLUSH.
- One natural sub-module: frame_pos_cnt, the pixel/line counter pair with wrap and force-advance.
- The FSM, error logic and output registers stay in the top level.

Test Plan:
- IMG_WIDTH=8, IMG_HEIGHT=4, cfg_enable=1, one clean frame, continuous valid:
  - no m_axis_tvalid during input line 0;
  - 24 passthrough beats, then 8 flush beats with m_flush=1 and s_axis_tready=0;
  - 4 m_axis_tlast pulses; one m_axis_tuser; frame_cnt=1.
- cfg_bayer_type changed 00->11 mid-frame:
  - bayer_type stays 00 for the whole frame;
  - becomes 11 one cycle after the next tuser beat.
- tlast injected at pixel 5 of line 2:
  - err_line=1 next cycle; line_idx advances; pixel_idx restarts at 0;
  - err_clr pulse -> err_line=0.
- tuser on input line 2:
  - err_frame=1; no flush beats; frame_cnt unchanged;
  - new frame starts priming with its tuser beat as pixel 0.
- Random s_axis_tvalid gaps (50%):
  - beat counts and tuser/tlast positions identical to the clean frame;
  - m_axis_tvalid only on accepted beats.
- rst_n asserted mid-FLUSH:
  - all outputs go to reset values immediately (asynchronous), state IDLE;
  - after release, the first frame behaves like the clean frame.
